// File: rtl/sa_input_skew.sv
// Input skew buffer for a systolic array.
//
// Row r of each accepted activation vector is delayed by r+1 advance cycles,
// so the core sees the diagonal wavefront it expects. Every stage carries a
// tag bit so that inserted bubbles can be told apart from real zero data.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no stream open; accept starts a new one
//   STREAM | stream open; beats accepted until in_last
//   FLUSH  | last beat taken; input blocked while the diagonal drains
module sa_input_skew #(
    parameter int ROWS = 8,
    parameter int DW   = 8,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [ROWS*DW-1:0]   in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 core_ready,
    output logic [ROWS*DW-1:0]   skew_data,
    output logic                 skew_valid,
    output logic                 busy,
    output logic [CW-1:0]        vec_count
);

    localparam int FW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]   vec_count_q, vec_count_d;

    logic            advance;
    logic            accept;
    logic [ROWS-1:0] last_tag;
    logic [ROWS-1:0] row_busy;

    assign advance  = core_ready;
    assign in_ready = core_ready & (state_q != FLUSH);
    assign accept   = in_valid & in_ready;

    // Per-row delay lines; row r is r+1 stages deep.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW:0] line_q [0:r];
        logic [DW:0] line_d [0:r];
        logic        any_tag;

        // Shift the whole line on advance; a non-accepted slot enters as a tagged-off zero.
        always_comb begin
            for (int s = 0; s <= r; s++) begin
                line_d[s] = line_q[s];
            end
            if (advance) begin
                line_d[0] = accept ? {1'b1, in_data[r*DW +: DW]} : '0;
                for (int s = 1; s <= r; s++) begin
                    line_d[s] = line_q[s-1];
                end
            end
        end

        // Line registers; reset discards anything in flight.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s <= r; s++) begin
                    line_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s <= r; s++) begin
                    line_q[s] <= line_d[s];
                end
            end
        end

        // Any real element still inside this row keeps the block busy.
        always_comb begin
            any_tag = 1'b0;
            for (int s = 0; s <= r; s++) begin
                any_tag = any_tag | line_q[s][DW];
            end
        end

        assign skew_data[r*DW +: DW] = line_q[r][DW-1:0];
        assign last_tag[r]           = line_q[r][DW];
        assign row_busy[r]           = any_tag;
    end

    // Stream sequencing, flush countdown and vector counting.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        vec_count_d = vec_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    vec_count_d = CW'(1);
                    if (in_last) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FW'(ROWS - 1);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    if (vec_count_q != {CW{1'b1}}) begin
                        vec_count_d = vec_count_q + CW'(1);
                    end
                    if (in_last) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FW'(ROWS - 1);
                    end
                end
            end
            FLUSH: begin
                if (advance) begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                    if (flush_cnt_q == FW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            vec_count_q <= vec_count_d;
        end
    end

    assign skew_valid = |last_tag;
    assign busy       = (state_q != IDLE) | (|row_busy);
    assign vec_count  = vec_count_q;

endmodule

// File: tb/tb_sa_input_skew.sv
// Bench for sa_input_skew: scripted and random streams against a queue-based
// reference of the skew (row r repeats what entered it r+1 advances earlier).
module tb_sa_input_skew;

    localparam int ROWS = 8;
    localparam int DW   = 8;
    localparam int CW   = 16;
    localparam int VW   = ROWS * DW;

    logic          clk = 1'b0;
    logic          rstn;
    logic [VW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          core_ready;
    logic [VW-1:0] skew_data;
    logic          skew_valid;
    logic          busy;
    logic [CW-1:0] vec_count;

    sa_input_skew #(.ROWS(ROWS), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .core_ready (core_ready),
        .skew_data  (skew_data),
        .skew_valid (skew_valid),
        .busy       (busy),
        .vec_count  (vec_count)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [DW:0] row_q [ROWS][$];
    logic [DW:0] cur_exp [ROWS];
    int          fl;
    bit          in_stream;
    int          vc;
    int          adv_pending;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < ROWS; r++) begin
            row_q[r].delete();
            for (int k = 0; k < r; k++) row_q[r].push_back('0);
            cur_exp[r] = '0;
        end
        fl          = 0;
        in_stream   = 1'b0;
        vc          = 0;
        adv_pending = 0;
    endfunction

    // One clock of stimulus; the model is told what the edge did.
    task automatic step(input bit v, input bit l, input bit cr, input logic [VW-1:0] d);
        bit          acc;
        logic [DW:0] ent;
        in_valid   = v;
        in_last    = l;
        core_ready = cr;
        in_data    = d;
        @(posedge clk);
        if (rstn) begin
            acc = v && cr && (fl == 0);
            if (cr) begin
                for (int r = 0; r < ROWS; r++) begin
                    ent = acc ? {1'b1, d[r*DW +: DW]} : '0;
                    row_q[r].push_back(ent);
                end
                adv_pending++;
                if (fl > 0) fl--;
            end
            if (acc) begin
                if (!in_stream) vc = 1;
                else if (vc < (1 << CW) - 1) vc++;
                if (l) begin
                    fl        = ROWS - 1;
                    in_stream = 1'b0;
                end else begin
                    in_stream = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
    endtask

    function automatic logic [VW-1:0] vec_all(input logic [DW-1:0] b);
        logic [VW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = b;
        return v;
    endfunction

    // Monitor: consume one expected slot per advance and compare every cycle.
    always @(negedge clk) begin
        logic [VW-1:0] ev;
        logic          evld;
        logic          ebusy;
        if (adv_pending > 0) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_q[r].size() == 0) begin
                    tot_cnt++;
                    $display("FAIL row_queue_underflow: row %0d empty, expected an entry", r);
                end else begin
                    cur_exp[r] = row_q[r].pop_front();
                end
            end
            adv_pending = 0;
        end
        evld  = 1'b0;
        ebusy = in_stream || (fl > 0);
        for (int r = 0; r < ROWS; r++) begin
            ev[r*DW +: DW] = cur_exp[r][DW-1:0];
            evld  = evld | cur_exp[r][DW];
            ebusy = ebusy | cur_exp[r][DW];
            foreach (row_q[r][k]) ebusy = ebusy | row_q[r][k][DW];
        end
        check("skew_data",  skew_data,  ev);
        check("skew_valid", skew_valid, evld);
        check("in_ready",   in_ready,   core_ready && (fl == 0));
        check("busy",       busy,       ebusy);
        check("vec_count",  vec_count,  vc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n;
        logic [VW-1:0] d;
        rstn       = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        core_ready = 1'b1;
        in_data    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",      busy, 0);
        check("reset_vec_count", vec_count, 0);
        rstn = 1'b1;

        // single vector with in_last
        for (int r = 0; r < ROWS; r++) d[r*DW +: DW] = DW'((r + 1) * 8'h11);
        step(1'b1, 1'b1, 1'b1, d);
        idle(12);
        check("single_vec_count", vec_count, 1);
        check("single_busy_done", busy, 0);

        // 16 back-to-back vectors, then count blocked cycles
        for (int i = 0; i < 16; i++) step(1'b1, (i == 15), 1'b1, vec_all(DW'(i % 16)));
        n = 0;
        while (!in_ready && n < 20) begin
            n++;
            step(1'b0, 1'b0, 1'b1, '0);
        end
        check("flush_block_cycles", n, 7);
        idle(10);
        check("burst_vec_count", vec_count, 16);

        // stall mid-stream: beat 4 offered while core_ready is low
        for (int i = 0; i < 8; i++) begin
            if (i == 4) for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, vec_all(DW'(8'hA0 + i)));
            step(1'b1, (i == 7), 1'b1, vec_all(DW'(8'hA0 + i)));
        end
        idle(12);
        check("stall_vec_count", vec_count, 8);

        // gap of two invalid cycles mid-stream
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                step(1'b0, 1'b1, 1'b1, vec_all(8'hEE));
                step(1'b0, 1'b0, 1'b1, vec_all(8'hEE));
            end
            step(1'b1, (i == 5), 1'b1, vec_all(DW'(8'hC0 + i)));
        end
        idle(12);
        check("gap_vec_count", vec_count, 6);

        // reset during FLUSH, then a fresh stream
        for (int i = 0; i < 4; i++) step(1'b1, (i == 3), 1'b1, {$urandom, $urandom});
        step(1'b0, 1'b0, 1'b1, '0);
        rstn = 1'b0;
        model_reset();
        #1;
        check("midrst_skew_data",  skew_data, 0);
        check("midrst_skew_valid", skew_valid, 0);
        check("midrst_busy",       busy, 0);
        check("midrst_vec_count",  vec_count, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b1, 1'b1, 1'b1, vec_all(8'h5A));
        idle(12);
        check("post_rst_vec_count", vec_count, 1);

        // valid/last pulse during FLUSH must be ignored
        for (int i = 0; i < 3; i++) step(1'b1, (i == 2), 1'b1, vec_all(DW'(8'h30 + i)));
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b1, vec_all(8'hFF));
        idle(12);
        check("flush_pulse_vec_count", vec_count, 3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 10) == 0, ($urandom % 5) != 0, {$urandom, $urandom});
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, '0);
        check("final_busy", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
